// File: rtl/iob_picorv32_bus_arb_pkg.sv
// rtl/iob_picorv32_bus_arb_pkg.sv - shared owner/grant types and defaults for the I/D bus arbiter
package iob_picorv32_bus_arb_pkg;

   typedef logic owner_t;
   typedef owner_t grant_t;

   localparam owner_t OWNER_I = 1'b0;
   localparam owner_t OWNER_D = 1'b1;

   localparam int OUTST_W_DEF = 2;

endpackage

// File: rtl/iob_picorv32_bus_arb_if.sv
// rtl/iob_picorv32_bus_arb_if.sv - I, D and manager IOb signal bundle for the bus arbiter
interface iob_picorv32_bus_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  i_valid_i;
   logic [ADDR_W-1:0]     i_addr_i;
   logic [DATA_W-1:0]     i_wdata_i;
   logic [DATA_W/8-1:0]   i_wstrb_i;
   logic [DATA_W-1:0]     i_rdata_o;
   logic                  i_rvalid_o;
   logic                  i_ready_o;

   logic                  d_valid_i;
   logic [ADDR_W-1:0]     d_addr_i;
   logic [DATA_W-1:0]     d_wdata_i;
   logic [DATA_W/8-1:0]   d_wstrb_i;
   logic [DATA_W-1:0]     d_rdata_o;
   logic                  d_rvalid_o;
   logic                  d_ready_o;

   logic                  m_valid_o;
   logic [ADDR_W-1:0]     m_addr_o;
   logic [DATA_W-1:0]     m_wdata_o;
   logic [DATA_W/8-1:0]   m_wstrb_o;
   logic [DATA_W-1:0]     m_rdata_i;
   logic                  m_rvalid_i;
   logic                  m_ready_i;

   modport slave (
      input  i_valid_i, i_addr_i, i_wdata_i, i_wstrb_i,
      output i_rdata_o, i_rvalid_o, i_ready_o,
      input  d_valid_i, d_addr_i, d_wdata_i, d_wstrb_i,
      output d_rdata_o, d_rvalid_o, d_ready_o,
      output m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o,
      input  m_rdata_i, m_rvalid_i, m_ready_i
   );

   modport master (
      output i_valid_i, i_addr_i, i_wdata_i, i_wstrb_i,
      input  i_rdata_o, i_rvalid_o, i_ready_o,
      output d_valid_i, d_addr_i, d_wdata_i, d_wstrb_i,
      input  d_rdata_o, d_rvalid_o, d_ready_o,
      input  m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o,
      output m_rdata_i, m_rvalid_i, m_ready_i
   );

endinterface

// File: rtl/iob_picorv32_bus_arb_owner_fifo.sv
// rtl/iob_picorv32_bus_arb_owner_fifo.sv - in-order owner FIFO for outstanding reads
module iob_picorv32_bus_arb_owner_fifo
   import iob_picorv32_bus_arb_pkg::*;
#(
   parameter int OUTST_W = OUTST_W_DEF
) (
   input  logic   clk_i,
   input  logic   arst_i,
   input  logic   cke_i,
   input  logic   push_i,
   input  owner_t owner_i,
   input  logic   pop_i,
   output owner_t head_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int DEPTH = 2**OUTST_W;

   logic [DEPTH-1:0]   r_mem;
   logic [OUTST_W-1:0] r_wptr;
   logic [OUTST_W-1:0] r_rptr;
   logic [OUTST_W:0]   r_cnt;
   logic               w_push;
   logic               w_pop;

   assign full_o  = (r_cnt == (OUTST_W+1)'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign head_o  = r_mem[r_rptr];
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (cke_i && w_push) r_mem[r_wptr] <= owner_i;
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (cke_i) begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (OUTST_W+1)'(1);
            2'b01:   r_cnt <= r_cnt - (OUTST_W+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/iob_picorv32_bus_arb.sv
// rtl/iob_picorv32_bus_arb.sv - merges picorv32 I and D buses onto one IOb manager port
// Build option: IOB_PICORV32_BUS_ARB_RR_EN selects round-robin instead of D-first priority.
module iob_picorv32_bus_arb
   import iob_picorv32_bus_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int OUTST_W = OUTST_W_DEF
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic cke_i,
   iob_picorv32_bus_arb_if.slave bus,
   output logic err_o
);

   logic   r_lock;
   grant_t r_grant;
   owner_t r_last;
   logic   r_err;

   grant_t w_grant;
   grant_t w_winner;
   logic   w_locked;
   logic   w_gvalid;
   logic   w_accept;
   logic   w_push;
   logic   w_pop;
   logic   w_full;
   logic   w_empty;
   owner_t w_head;

`ifdef IOB_PICORV32_BUS_ARB_RR_EN
   assign w_winner = (r_last == OWNER_D) ? OWNER_I : OWNER_D;
`else
   // fixed priority: D wins whatever the history
   assign w_winner = (r_last == OWNER_I) ? OWNER_D : OWNER_D;
`endif

   // a lock only holds while its owner keeps valid asserted
   assign w_locked = r_lock & ((r_grant == OWNER_I) ? bus.i_valid_i : bus.d_valid_i);

   always_comb begin
      w_grant = OWNER_D;
      if (w_locked)                          w_grant = r_grant;
      else if (bus.i_valid_i && bus.d_valid_i) w_grant = w_winner;
      else if (bus.i_valid_i)                w_grant = OWNER_I;
   end

   assign w_gvalid      = (w_grant == OWNER_I) ? bus.i_valid_i : bus.d_valid_i;
   assign bus.m_valid_o = w_gvalid & ~w_full;
   assign bus.m_addr_o  = (w_grant == OWNER_I) ? bus.i_addr_i  : bus.d_addr_i;
   assign bus.m_wdata_o = (w_grant == OWNER_I) ? bus.i_wdata_i : bus.d_wdata_i;
   assign bus.m_wstrb_o = (w_grant == OWNER_I) ? bus.i_wstrb_i : bus.d_wstrb_i;

   assign w_accept      = bus.m_valid_o & bus.m_ready_i;
   assign bus.i_ready_o = w_accept & (w_grant == OWNER_I);
   assign bus.d_ready_o = w_accept & (w_grant == OWNER_D);
   assign w_push        = w_accept & (bus.m_wstrb_o == '0);
   assign w_pop         = bus.m_rvalid_i & ~w_empty;

   assign bus.i_rvalid_o = w_pop & (w_head == OWNER_I);
   assign bus.d_rvalid_o = w_pop & (w_head == OWNER_D);
   assign bus.i_rdata_o  = bus.m_rdata_i;
   assign bus.d_rdata_o  = bus.m_rdata_i;
   assign err_o          = r_err;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_lock  <= 1'b0;
         r_grant <= OWNER_D;
         r_last  <= OWNER_D;
         r_err   <= 1'b0;
      end else if (cke_i) begin
         r_lock <= bus.m_valid_o & ~bus.m_ready_i;
         if (bus.m_valid_o && !bus.m_ready_i) r_grant <= w_grant;
         if (w_accept) r_last <= w_grant;
         if (bus.m_rvalid_i && w_empty) r_err <= 1'b1;
      end
   end

   iob_picorv32_bus_arb_owner_fifo #(
      .OUTST_W (OUTST_W)
   ) u_owner_fifo (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .cke_i   (cke_i),
      .push_i  (w_push),
      .owner_i (w_grant),
      .pop_i   (w_pop),
      .head_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

endmodule

// File: tb/tb_iob_picorv32_bus_arb.sv
// tb/tb_iob_picorv32_bus_arb.sv - scoreboard bench for the I/D bus arbiter
module tb_iob_picorv32_bus_arb;

   logic clk = 1'b0;
   logic arst;
   logic cke;
   logic err;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   sbq[$];

   iob_picorv32_bus_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   iob_picorv32_bus_arb #(.ADDR_W(32), .DATA_W(32), .OUTST_W(2)) dut (
      .clk_i  (clk),
      .arst_i (arst),
      .cke_i  (cke),
      .bus    (bus),
      .err_o  (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic resp(input logic [31:0] data);
      bit e;
      bus.m_rvalid_i = 1'b1;
      bus.m_rdata_i  = data;
      #1;
      if (sbq.size() == 0) begin
         chk("rv_i_none", bus.i_rvalid_o, 1'b0);
         chk("rv_d_none", bus.d_rvalid_o, 1'b0);
      end else begin
         e = sbq.pop_front();
         chk("rv_i", bus.i_rvalid_o, e == 1'b0);
         chk("rv_d", bus.d_rvalid_o, e == 1'b1);
         chk("rdata", e ? bus.d_rdata_o : bus.i_rdata_o, data);
      end
      @(negedge clk);
      bus.m_rvalid_i = 1'b0;
   endtask

   initial begin
      arst = 1'b1;
      cke  = 1'b1;
      bus.i_valid_i = 0; bus.i_addr_i = 0; bus.i_wdata_i = 0; bus.i_wstrb_i = 0;
      bus.d_valid_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0; bus.d_wstrb_i = 0;
      bus.m_rdata_i = 0; bus.m_rvalid_i = 0; bus.m_ready_i = 0;
      cyc(); cyc();
      chk("rst_err", err, 1'b0);
      chk("rst_mvalid", bus.m_valid_o, 1'b0);
      chk("rst_iready", bus.i_ready_o, 1'b0);
      chk("rst_dready", bus.d_ready_o, 1'b0);
      chk("rst_rvalid", {bus.i_rvalid_o, bus.d_rvalid_o}, 2'b00);
      arst = 1'b0;

      // conflict: both read in the same cycle
      cyc();
      bus.i_valid_i = 1; bus.i_addr_i = 32'h100;
      bus.d_valid_i = 1; bus.d_addr_i = 32'h200;
      bus.m_ready_i = 1;
      #1;
`ifdef IOB_PICORV32_BUS_ARB_RR_EN
      chk("cf_addr0", bus.m_addr_o, 32'h100);
      chk("cf_iready0", bus.i_ready_o, 1'b1);
      sbq.push_back(1'b0);
      cyc(); bus.i_valid_i = 0; #1;
      chk("cf_addr1", bus.m_addr_o, 32'h200);
      chk("cf_dready1", bus.d_ready_o, 1'b1);
      sbq.push_back(1'b1);
      cyc(); bus.d_valid_i = 0;
`else
      chk("cf_addr0", bus.m_addr_o, 32'h200);
      chk("cf_dready0", bus.d_ready_o, 1'b1);
      chk("cf_iready0", bus.i_ready_o, 1'b0);
      sbq.push_back(1'b1);
      cyc(); bus.d_valid_i = 0; #1;
      chk("cf_addr1", bus.m_addr_o, 32'h100);
      chk("cf_iready1", bus.i_ready_o, 1'b1);
      sbq.push_back(1'b0);
      cyc(); bus.i_valid_i = 0;
`endif
      resp(32'hAAAA);
      resp(32'hBBBB);

      // lock: I stalls three cycles while D waits
      bus.i_valid_i = 1; bus.i_addr_i = 32'h100; bus.m_ready_i = 0;
      #1 chk("lk_addr0", bus.m_addr_o, 32'h100);
      for (int k = 1; k < 3; k++) begin
         cyc(); bus.d_valid_i = 1; bus.d_addr_i = 32'h200; #1;
         chk("lk_addr", bus.m_addr_o, 32'h100);
         chk("lk_dready", bus.d_ready_o, 1'b0);
      end
      cyc(); bus.m_ready_i = 1; #1;
      chk("lk_addr3", bus.m_addr_o, 32'h100);
      chk("lk_iready", bus.i_ready_o, 1'b1);
      chk("lk_dready3", bus.d_ready_o, 1'b0);
      sbq.push_back(1'b0);
      cyc(); bus.i_valid_i = 0; #1;
      chk("lk_daddr", bus.m_addr_o, 32'h200);
      chk("lk_dready4", bus.d_ready_o, 1'b1);
      sbq.push_back(1'b1);
      cyc(); bus.d_valid_i = 0;
      resp(32'h11);
      resp(32'h22);

      // full: four outstanding I reads block a fifth
      bus.i_valid_i = 1;
      for (int k = 0; k < 4; k++) begin
         bus.i_addr_i = 32'h400 + 32'(4*k); #1;
         chk("fl_iready", bus.i_ready_o, 1'b1);
         sbq.push_back(1'b0);
         cyc();
      end
      bus.i_addr_i = 32'h410; #1;
      chk("fl_mvalid_full", bus.m_valid_o, 1'b0);
      chk("fl_iready_full", bus.i_ready_o, 1'b0);
      cyc();
      bus.m_rvalid_i = 1; bus.m_rdata_i = 32'h40; #1;
      chk("fl_mvalid_pop", bus.m_valid_o, 1'b0);
      chk("fl_iready_pop", bus.i_ready_o, 1'b0);
      chk("fl_rv_i", bus.i_rvalid_o, sbq.pop_front() == 1'b0);
      chk("fl_rdata", bus.i_rdata_o, 32'h40);
      cyc(); bus.m_rvalid_i = 0; #1;
      chk("fl_mvalid_next", bus.m_valid_o, 1'b1);
      chk("fl_addr_next", bus.m_addr_o, 32'h410);
      chk("fl_iready_next", bus.i_ready_o, 1'b1);
      sbq.push_back(1'b0);
      cyc(); bus.i_valid_i = 0;
      for (int k = 0; k < 4; k++) resp(32'h41 + 32'(k));

      // mixed: D write between two I reads
      bus.i_valid_i = 1; bus.i_addr_i = 32'h500; #1;
      chk("mx_iready0", bus.i_ready_o, 1'b1);
      sbq.push_back(1'b0);
      cyc(); bus.i_valid_i = 0;
      bus.d_valid_i = 1; bus.d_addr_i = 32'h300; bus.d_wdata_i = 32'hDEADBEEF; bus.d_wstrb_i = 4'hF; #1;
      chk("mx_dready", bus.d_ready_o, 1'b1);
      chk("mx_wstrb", bus.m_wstrb_o, 4'hF);
      chk("mx_wdata", bus.m_wdata_o, 32'hDEADBEEF);
      cyc(); bus.d_valid_i = 0; bus.d_wstrb_i = 0;
      bus.i_valid_i = 1; bus.i_addr_i = 32'h504; #1;
      chk("mx_iready1", bus.i_ready_o, 1'b1);
      sbq.push_back(1'b0);
      cyc(); bus.i_valid_i = 0;
      resp(32'h5A);
      resp(32'h5B);
      chk("mx_err", err, 1'b0);

      // error: response with nothing outstanding
      resp(32'hEE);
      chk("er_set", err, 1'b1);
      cyc();
      chk("er_sticky", err, 1'b1);
      arst = 1'b1; #1;
      chk("er_clear", err, 1'b0);
      cyc(); arst = 1'b0;

      // clock enable: FIFO and lock frozen
      bus.i_valid_i = 1; bus.i_addr_i = 32'h600; #1;
      sbq.push_back(1'b0);
      cyc(); bus.i_valid_i = 0; cke = 0;
      bus.m_rvalid_i = 1; bus.m_rdata_i = 32'h61; #1;
      chk("ck_rv_frozen", bus.i_rvalid_o, 1'b1);
      cyc(); cke = 1;
      resp(32'h62);
      chk("ck_err", err, 1'b0);
      bus.i_valid_i = 1; bus.i_addr_i = 32'h700; bus.m_ready_i = 0;
      cyc(); cke = 0; bus.d_valid_i = 1; bus.d_addr_i = 32'h800; bus.m_ready_i = 1; #1;
      chk("ck_lock_acc", bus.m_addr_o, 32'h700);
      cyc(); bus.m_ready_i = 0; #1;
      chk("ck_lock_held", bus.m_addr_o, 32'h700);
      cyc(); cke = 1; bus.i_valid_i = 0; bus.d_valid_i = 0;
      resp(32'h77);
      chk("ck_nopush_err", err, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iob_picorv32_bus_arb.md
Name: iob_picorv32_bus_arb

Overview:
Merges the CPU wrapper's instruction bus (port I) and data bus (port D) onto a single IOb native manager port for a single-ported external memory or cache.
- Arbitrates between the two requesters and keeps the grant stable while a request is stalled.
- Tracks the owner of each outstanding read in order, so every rvalid/rdata is routed back to the requester that issued it.
- Sits between iob_picorv32 and the external memory controller when both buses target the same memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; strobe width is DATA_W/8
OUTST_W, 2, log2 of the maximum number of outstanding reads (default 4)

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous active-high reset
cke_i  in  1  clock enable; all registers hold state when low
i_valid_i  in  1  port I request valid
i_addr_i  in  ADDR_W  port I address
i_wdata_i  in  DATA_W  port I write data
i_wstrb_i  in  DATA_W/8  port I write strobe; 0 means read
i_rdata_o  out  DATA_W  port I read data
i_rvalid_o  out  1  port I read data valid
i_ready_o  out  1  port I request accepted
d_valid_i, d_addr_i, d_wdata_i, d_wstrb_i, d_rdata_o, d_rvalid_o, d_ready_o  same as port I, for port D
m_valid_o  out  1  manager request valid
m_addr_o  out  ADDR_W  manager address
m_wdata_o  out  DATA_W  manager write data
m_wstrb_o  out  DATA_W/8  manager write strobe
m_rdata_i  in  DATA_W  memory read data
m_rvalid_i  in  1  memory read data valid
m_ready_i  in  1  memory accepts request
err_o  out  1  sticky protocol error

Behaviour:
- Reset values:
  - FIFO empty; lock=0; last_grant=D; err_o=0.
  - All *_ready_o, *_rvalid_o and m_valid_o are 0.
  - rdata outputs are don't-care.
- Request path is combinational. m_* carries the granted requester's signals. m_valid_o = granted valid & ~fifo_full.
- Ready routing: granted_ready_o = m_ready_i & m_valid_o. The non-granted ready_o is 0.
- Accept event: m_valid_o & m_ready_i. A request is a read if wstrb==0, otherwise a write.
- Grant selection when unlocked:
  - Only one port valid: that port is granted.
  - Both ports valid: resolved by the priority rule (see Optional Feature).
  - Neither valid: grant is don't-care and m_valid_o=0.
- Lock rule:
  - If m_valid_o & ~m_ready_i, the next cycle has lock=1 with grant_reg = current grant.
  - While locked, the grant is forced to grant_reg.
  - The lock clears on accept.
  - A requester that drops valid while locked clears the lock. This is legal and not flagged.
- last_grant updates on every accept.
- Owner FIFO:
  - Depth 2^OUTST_W, 1-bit entries (0=I, 1=D).
  - Push the owner on every read accept.
  - Pop on m_rvalid_i.
- Response routing:
  - On m_rvalid_i, the head owner selects i_rvalid_o or d_rvalid_o. Latency is 0 (combinational from m_rvalid_i).
  - m_rdata_i fans out to both rdata outputs.
  - Responses are strictly in order.
- Writes: never pushed to the FIFO, and allowed while reads are outstanding. Write completion is the ready pulse.
- FIFO full: m_valid_o=0 and both readies are 0, even if a pop occurs in the same cycle. The requests are issued next cycle.
- Push and pop in the same cycle with the FIFO not full: occupancy is unchanged.
- m_rvalid_i with FIFO empty: ignored (both rvalids 0) and err_o set. err_o clears only on reset.
- Reset mid-operation: FIFO flushed. Responses arriving after reset from pre-reset reads are treated as error events.

Optional Feature:
IOB_PICORV32_BUS_ARB_RR_EN
- Defined: round-robin on conflict. The port not equal to last_grant wins. With last_grant=D at reset, the first conflict goes to I.
- Undefined: fixed priority, D always wins on conflict. last_grant is still maintained but unused.

Decomposition:
- Package/include iob_picorv32_bus_arb_pkg:
  - OWNER_I=1'b0 and OWNER_D=1'b1 constants.
  - Owner and grant typedef.
  - Default OUTST_W.
- Sub-module iob_picorv32_bus_arb_owner_fifo: synchronous-write register FIFO with push, pop, head, full and empty outputs, parameter OUTST_W, using clk_i, arst_i and cke_i.

Test Plan:
- I read 0x100 and D read 0x200 assert in the same cycle, m_ready_i=1, memory returns 0xAAAA then 0xBBBB:
  - Without RR_EN: D is accepted first; d_rdata=0xAAAA, then i_rdata=0xBBBB.
  - With RR_EN: I is accepted first.
- Lock: I read stalls 3 cycles (m_ready_i=0) while D asserts valid at cycle 1 -> m_addr_o stays 0x100 for all cycles; d_ready_o=0 until I is accepted; D is accepted the next cycle.
- Full: OUTST_W=2, issue 4 I reads with no rvalid -> 5th read sees m_valid_o=0. On a single m_rvalid_i, the 5th is accepted the following cycle.
- Mixed: D write 0x300 with wstrb=0xF, issued between two outstanding I reads -> no FIFO push; both read responses reach I in order; d_rvalid_o never asserts.
- Error: m_rvalid_i pulse with no reads outstanding -> no rvalid output and err_o=1 until arst_i.
- cke_i=0 during an accept/rvalid sequence -> FIFO and lock state are frozen.
